// File: rtl/writeback_queue.sv
// Write-back stage: selects the retiring result and buffers register writes in an
// in-order queue that drains through one register-file port, exporting a pending-rd mask.
module writeback_queue #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [6:0]                 in_opcode,
    input  logic [2:0]                 in_funct3,
    input  logic [4:0]                 in_dest_reg,
    input  logic [XLEN-1:0]            in_pc,
    input  logic [XLEN-1:0]            alu_result,
    input  logic [XLEN-1:0]            loaded_data,
    input  logic                       rf_stall,
    output logic                       write_enable,
    output logic [4:0]                 write_reg,
    output logic [XLEN-1:0]            write_data,
    output logic [31:0]                pending_mask,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [4:0]      reg_q  [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;

    logic            has_write;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] load_ext;
    logic [XLEN-1:0] sext_word;
    logic            head_valid;
    logic            push;
    logic            pop;

    assign sext_word = XLEN'($signed(loaded_data[31:0]));

    // On RV32 the doubleword and unsigned-word sizes collapse onto LW.
    always_comb begin
        load_ext = loaded_data;
        case (in_funct3)
            3'b000:  load_ext = XLEN'($signed(loaded_data[7:0]));
            3'b001:  load_ext = XLEN'($signed(loaded_data[15:0]));
            3'b010:  load_ext = sext_word;
            3'b011:  load_ext = (XLEN > 32) ? loaded_data : sext_word;
            3'b100:  load_ext = XLEN'(loaded_data[7:0]);
            3'b101:  load_ext = XLEN'(loaded_data[15:0]);
            3'b110:  load_ext = (XLEN > 32) ? XLEN'(loaded_data[31:0]) : sext_word;
            default: load_ext = loaded_data;
        endcase
    end

    always_comb begin
        has_write = 1'b0;
        result    = '0;
        case (in_opcode)
            7'b0110011, 7'b0111011, 7'b0010011,
            7'b0011011, 7'b0010111, 7'b0110111: begin
                has_write = 1'b1;
                result    = alu_result;
            end
            7'b0000011: begin
                has_write = 1'b1;
                result    = load_ext;
            end
            7'b1101111, 7'b1100111: begin
                has_write = 1'b1;
                result    = in_pc + XLEN'(4);
            end
            default: begin
                has_write = 1'b0;
                result    = '0;
            end
        endcase
    end

    assign head_valid   = valid_q[head_ptr];
    assign write_enable = head_valid && !rf_stall;
    assign pop          = write_enable;
    // A full queue still accepts when the head leaves in the same cycle.
    assign in_ready     = (count < CNT_W'(DEPTH)) || write_enable;
    assign push         = in_valid && in_ready && has_write && (in_dest_reg != 5'd0);
    assign write_reg    = head_valid ? reg_q[head_ptr]  : '0;
    assign write_data   = head_valid ? data_q[head_ptr] : '0;

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i]) pending_mask[reg_q[i]] = 1'b1;
        end
        pending_mask[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q  <= '0;
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                reg_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            // Pop clears before push sets, so a full-queue swap keeps the slot valid.
            if (pop) begin
                valid_q[head_ptr] <= 1'b0;
                head_ptr          <= head_ptr + PTR_W'(1);
            end
            if (push) begin
                valid_q[tail_ptr] <= 1'b1;
                reg_q[tail_ptr]   <= in_dest_reg;
                data_q[tail_ptr]  <= result;
                tail_ptr          <= tail_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_writeback_queue.sv
// Self-checking bench for writeback_queue: scoreboard of expected register writes
// plus per-scenario checks of handshake, occupancy and pending mask.
module tb_writeback_queue;

    localparam int XLEN  = 64;
    localparam int DEPTH = 4;

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OP32   = 7'b0111011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [6:0]      in_opcode = '0;
    logic [2:0]      in_funct3 = '0;
    logic [4:0]      in_dest_reg = '0;
    logic [XLEN-1:0] in_pc = '0;
    logic [XLEN-1:0] alu_result = '0;
    logic [XLEN-1:0] loaded_data = '0;
    logic            rf_stall = 1'b0;
    logic            write_enable;
    logic [4:0]      write_reg;
    logic [XLEN-1:0] write_data;
    logic [31:0]     pending_mask;
    logic [2:0]      count;

    exp_t            sb[$];
    logic [XLEN-1:0] rf_model [32];
    int              n_cmp = 0;
    int              n_fail = 0;

    writeback_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_funct3(in_funct3), .in_dest_reg(in_dest_reg),
        .in_pc(in_pc), .alu_result(alu_result), .loaded_data(loaded_data),
        .rf_stall(rf_stall), .write_enable(write_enable), .write_reg(write_reg),
        .write_data(write_data), .pending_mask(pending_mask), .count(count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Every observed register write is popped against the scoreboard head.
    always @(negedge clk) begin
        if (write_enable === 1'b1) begin
            exp_t e;
            n_cmp++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_write: got write x%0d=%h, expected no write", write_reg, write_data);
            end else begin
                e = sb.pop_front();
                if (write_reg !== e.rd || write_data !== e.data) begin
                    n_fail++;
                    $display("FAIL sb_write: got x%0d=%h, expected x%0d=%h", write_reg, write_data, e.rd, e.data);
                end
            end
            rf_model[write_reg] = write_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                        input logic [XLEN-1:0] pc, input logic [XLEN-1:0] alu,
                        input logic [XLEN-1:0] ld, input logic wr, input logic [XLEN-1:0] exp_d);
        bit acc = 1'b0;
        in_valid = 1'b1; in_opcode = op; in_funct3 = f3; in_dest_reg = rd;
        in_pc = pc; alu_result = alu; loaded_data = ld;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                acc = 1'b1;
                if (wr && rd != 5'd0) sb.push_back('{rd: rd, data: exp_d});
            end
            tick();
        end
        n_cmp++;
        if (!acc) begin
            n_fail++;
            $display("FAIL send_accept: rd=%0d in_ready=%b for 20 cycles, expected 1", rd, in_ready);
        end
    endtask

    task automatic wait_drain();
        bit done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (count === 3'd0 && sb.size() == 0) done = 1'b1;
        end
        tick();
        n_cmp++;
        if (!done) begin
            n_fail++;
            $display("FAIL drain: count=%0d pending_writes=%0d after 50 cycles, expected 0/0", count, sb.size());
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_cmp++; if (write_enable !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b expected 0", write_enable); end
        n_cmp++; if (write_reg !== 5'd0) begin n_fail++; $display("FAIL reset_reg: got %0d expected 0", write_reg); end
        n_cmp++; if (write_data !== 64'd0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", write_data); end
        n_cmp++; if (pending_mask !== 32'd0) begin n_fail++; $display("FAIL reset_pending: got %h expected 0", pending_mask); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_alu_latency();
        in_valid = 1'b1; in_opcode = OP_IMM; in_funct3 = 3'b000; in_dest_reg = 5'd5;
        in_pc = '0; alu_result = 64'h2A; loaded_data = '0;
        @(negedge clk);
        n_cmp++; if (write_enable !== 1'b0) begin n_fail++; $display("FAIL no_bypass_we: got %b expected 0", write_enable); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL alu_ready: got %b expected 1", in_ready); end
        sb.push_back('{rd: 5'd5, data: 64'h2A});
        tick();
        idle();
        @(negedge clk);
        n_cmp++; if (write_enable !== 1'b1) begin n_fail++; $display("FAIL alu_we: got %b expected 1", write_enable); end
        n_cmp++; if (write_reg !== 5'd5) begin n_fail++; $display("FAIL alu_reg: got %0d expected 5", write_reg); end
        n_cmp++; if (write_data !== 64'h2A) begin n_fail++; $display("FAIL alu_data: got %h expected 2a", write_data); end
        n_cmp++; if (pending_mask !== 32'h20) begin n_fail++; $display("FAIL alu_pending_set: got %h expected 00000020", pending_mask); end
        n_cmp++; if (count !== 3'd1) begin n_fail++; $display("FAIL alu_count: got %0d expected 1", count); end
        tick();
        @(negedge clk);
        n_cmp++; if (pending_mask !== 32'h0) begin n_fail++; $display("FAIL alu_pending_clear: got %h expected 0", pending_mask); end
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL alu_count_after: got %0d expected 0", count); end
        n_cmp++; if (write_enable !== 1'b0) begin n_fail++; $display("FAIL alu_we_after: got %b expected 0", write_enable); end
        tick();
    endtask

    task automatic test_loads();
        send(OP_LOAD, 3'b000, 5'd6,  '0, '0, 64'hDEAD_BEEF_1234_5680, 1'b1, 64'hFFFF_FFFF_FFFF_FF80);
        send(OP_LOAD, 3'b101, 5'd7,  '0, '0, 64'h1111_2222_3333_FFFF, 1'b1, 64'h0000_0000_0000_FFFF);
        send(OP_LOAD, 3'b010, 5'd8,  '0, '0, 64'h0000_0001_8000_0000, 1'b1, 64'hFFFF_FFFF_8000_0000);
        send(OP_LOAD, 3'b011, 5'd9,  '0, '0, 64'h8123_4567_89AB_CDEF, 1'b1, 64'h8123_4567_89AB_CDEF);
        send(OP_LOAD, 3'b100, 5'd10, '0, '0, 64'hFFFF_FFFF_FFFF_FF90, 1'b1, 64'h0000_0000_0000_0090);
        send(OP_LOAD, 3'b110, 5'd11, '0, '0, 64'hFFFF_FFFF_8765_4321, 1'b1, 64'h0000_0000_8765_4321);
        send(OP_LOAD, 3'b001, 5'd12, '0, '0, 64'h0000_0000_1234_8001, 1'b1, 64'hFFFF_FFFF_FFFF_8001);
        send(OP_LOAD, 3'b111, 5'd13, '0, '0, 64'hCAFE_0000_0000_0001, 1'b1, 64'hCAFE_0000_0000_0001);
        idle();
        wait_drain();
    endtask

    task automatic test_no_write_and_jumps();
        send(OP_STORE,  3'b010, 5'd3, '0, 64'h11, '0, 1'b0, '0);
        send(OP_BRANCH, 3'b000, 5'd4, '0, 64'h22, '0, 1'b0, '0);
        send(OP_JALR,   3'b000, 5'd0, 64'h2000, 64'h33, '0, 1'b1, 64'h2004);
        send(OP_FENCE,  3'b000, 5'd5, '0, 64'h44, '0, 1'b0, '0);
        send(OP_SYSTEM, 3'b000, 5'd6, '0, 64'h55, '0, 1'b0, '0);
        send(OP_IMM,    3'b000, 5'd0, '0, 64'h66, '0, 1'b1, 64'h66);
        idle();
        @(negedge clk);
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL nowrite_count: got %0d expected 0", count); end
        n_cmp++; if (pending_mask !== 32'd0) begin n_fail++; $display("FAIL nowrite_pending: got %h expected 0", pending_mask); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL nowrite_ready: got %b expected 1", in_ready); end
        tick();
        send(OP_JAL,  3'b000, 5'd1, 64'h1000, 64'hBAD, '0, 1'b1, 64'h1004);
        send(OP_JALR, 3'b000, 5'd2, 64'hFFFF_FFFF_FFFF_FFFE, 64'hBAD, '0, 1'b1, 64'h2);
        idle();
        wait_drain();
    endtask

    task automatic test_back_to_back();
        send(OP_OP,    3'b000, 5'd20, '0, 64'hA000_0000_0000_0001, 64'h1, 1'b1, 64'hA000_0000_0000_0001);
        send(OP_OP32,  3'b000, 5'd21, '0, 64'hFFFF_FFFF_8000_0002, 64'h2, 1'b1, 64'hFFFF_FFFF_8000_0002);
        send(OP_LUI,   3'b000, 5'd22, '0, 64'h0000_0000_1234_5000, 64'h3, 1'b1, 64'h0000_0000_1234_5000);
        send(OP_AUIPC, 3'b000, 5'd23, 64'h40, 64'h0000_0000_0000_3040, 64'h4, 1'b1, 64'h0000_0000_0000_3040);
        send(OP_IMM32, 3'b000, 5'd24, '0, 64'h0000_0000_0000_0005, 64'h5, 1'b1, 64'h5);
        send(OP_OP,    3'b000, 5'd20, '0, 64'h0000_0000_0000_0006, 64'h6, 1'b1, 64'h6);
        idle();
        @(negedge clk);
        n_cmp++; if (count !== 3'd1) begin n_fail++; $display("FAIL b2b_count: got %0d expected 1", count); end
        n_cmp++; if (write_reg !== 5'd20) begin n_fail++; $display("FAIL b2b_head_reg: got %0d expected 20", write_reg); end
        tick();
        wait_drain();
    endtask

    task automatic test_stall_full();
        rf_stall = 1'b1;
        for (int i = 0; i < 4; i++)
            send(OP_IMM, 3'b000, 5'(10 + i), '0, 64'(256 + i), '0, 1'b1, 64'(256 + i));
        idle();
        @(negedge clk);
        n_cmp++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d expected 4", count); end
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b expected 0", in_ready); end
        n_cmp++; if (pending_mask !== 32'h0000_3C00) begin n_fail++; $display("FAIL full_pending: got %h expected 00003c00", pending_mask); end
        n_cmp++; if (write_enable !== 1'b0) begin n_fail++; $display("FAIL full_we_stalled: got %b expected 0", write_enable); end
        tick();
        in_valid = 1'b1; in_opcode = OP_IMM; in_funct3 = 3'b000; in_dest_reg = 5'd14;
        alu_result = 64'h104; in_pc = '0; loaded_data = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready[%0d]: got %b expected 0", k, in_ready); end
            n_cmp++; if (write_reg !== 5'd10 || write_data !== 64'h100) begin
                n_fail++; $display("FAIL stall_head[%0d]: got x%0d=%h expected x10=100", k, write_reg, write_data);
            end
            tick();
        end
        rf_stall = 1'b0;
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready: got %b expected 1", in_ready); end
        n_cmp++; if (write_enable !== 1'b1) begin n_fail++; $display("FAIL release_we: got %b expected 1", write_enable); end
        sb.push_back('{rd: 5'd14, data: 64'h104});
        tick();
        idle();
        @(negedge clk);
        n_cmp++; if (count !== 3'd4) begin n_fail++; $display("FAIL swap_count: got %0d expected 4", count); end
        n_cmp++; if (write_reg !== 5'd11) begin n_fail++; $display("FAIL swap_head: got %0d expected 11", write_reg); end
        tick();
        wait_drain();
    endtask

    task automatic test_same_rd();
        rf_stall = 1'b1;
        send(OP_IMM, 3'b000, 5'd7, '0, 64'd1, '0, 1'b1, 64'd1);
        send(OP_IMM, 3'b000, 5'd7, '0, 64'd2, '0, 1'b1, 64'd2);
        idle();
        @(negedge clk);
        n_cmp++; if (count !== 3'd2 || pending_mask !== 32'h80) begin
            n_fail++; $display("FAIL samerd_queued: got count=%0d mask=%h expected 2/00000080", count, pending_mask);
        end
        tick();
        rf_stall = 1'b0;
        @(negedge clk);
        n_cmp++; if (write_data !== 64'd1 || pending_mask !== 32'h80) begin
            n_fail++; $display("FAIL samerd_first: got data=%h mask=%h expected 1/00000080", write_data, pending_mask);
        end
        tick();
        @(negedge clk);
        n_cmp++; if (write_data !== 64'd2 || pending_mask !== 32'h80) begin
            n_fail++; $display("FAIL samerd_second: got data=%h mask=%h expected 2/00000080", write_data, pending_mask);
        end
        tick();
        @(negedge clk);
        n_cmp++; if (pending_mask !== 32'h0) begin n_fail++; $display("FAIL samerd_clear: got %h expected 0", pending_mask); end
        n_cmp++; if (rf_model[7] !== 64'd2) begin n_fail++; $display("FAIL samerd_final: got %h expected 2", rf_model[7]); end
        tick();
    endtask

    task automatic test_reset_mid();
        rf_stall = 1'b1;
        for (int i = 0; i < 3; i++)
            send(OP_IMM, 3'b000, 5'(15 + i), '0, 64'(32 + i), '0, 1'b1, 64'(32 + i));
        idle();
        @(negedge clk);
        n_cmp++; if (count !== 3'd3) begin n_fail++; $display("FAIL pre_reset_count: got %0d expected 3", count); end
        tick();
        reset = 1'b1;
        sb.delete();
        rf_stall = 1'b0;
        #1;
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL midreset_count: got %0d expected 0", count); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_ready: got %b expected 1", in_ready); end
        n_cmp++; if (write_enable !== 1'b0 || pending_mask !== 32'd0) begin
            n_fail++; $display("FAIL midreset_outputs: got we=%b mask=%h expected 0/0", write_enable, pending_mask);
        end
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (count !== 3'd0 || write_enable !== 1'b0) begin
            n_fail++; $display("FAIL postreset: got count=%0d we=%b expected 0/0", count, write_enable);
        end
        tick();
        send(OP_IMM, 3'b000, 5'd31, '0, 64'h5A5A, '0, 1'b1, 64'h5A5A);
        idle();
        wait_drain();
    endtask

    initial begin
        for (int r = 0; r < 32; r++) rf_model[r] = '0;
        test_reset();
        test_alu_latency();
        test_loads();
        test_no_write_and_jumps();
        test_back_to_back();
        test_stall_full();
        test_same_rd();
        test_reset_mid();
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL sb_leftover: got %0d outstanding writes expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
